// File: rtl/signed_div_sequencer_if.sv
// Request/result handshake bundle for signed_div_sequencer.
//   in_valid/in_ready   request handshake; in_dvnd, in_dvsr, in_sgn request payload
//   out_valid/out_ready result handshake; out_q, out_r, out_dz, out_ovf, out_err result payload
// master = requester/consumer side, slave = the sequencer.
interface signed_div_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dvnd;
  logic [WIDTH-1:0] in_dvsr;
  logic             in_sgn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic             out_dz;
  logic             out_ovf;
  logic             out_err;

  modport master (
    output in_valid, in_dvnd, in_dvsr, in_sgn, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_dz, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_dvnd, in_dvsr, in_sgn, out_ready,
    output in_ready, out_valid, out_q, out_r, out_dz, out_ovf, out_err
  );
endinterface

// File: rtl/signed_div_sequencer.sv
// Signed/unsigned wrapper around an unsigned iterative divider.
// Converts operands to magnitudes, pulses the divider, waits for its ready,
// sign-corrects quotient/remainder and holds the result until accepted.
// Divide-by-zero bypasses the divider; a divider that never answers times out.
// Ports:
//   clk, Rst         clock (rising edge), asynchronous active-low reset
//   bus (slave)      request/result handshake bundle
//   div_dvnd/dvsr    operand magnitudes to the divider, stable through WAIT
//   div_run          one-cycle start pulse to the divider
//   div_q/r/rdy      divider result and ready
module signed_div_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 80
) (
  input  logic                 clk,
  input  logic                 Rst,
  signed_div_sequencer_if.slave bus,
  output logic [WIDTH-1:0]     div_dvnd,
  output logic [WIDTH-1:0]     div_dvsr,
  output logic                 div_run,
  input  logic [WIDTH-1:0]     div_q,
  input  logic [WIDTH-1:0]     div_r,
  input  logic                 div_rdy
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] dvnd_nx, dvsr_nx, q_cap, q_cap_nx, r_cap, r_cap_nx;
  logic [WIDTH-1:0] out_q_nx, out_r_nx;
  logic             neg_q, neg_q_nx, neg_r, neg_r_nx, ovf_pend, ovf_pend_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             in_ready_nx, div_run_nx, out_valid_nx, dz_nx, ovf_nx, err_nx;

  // Magnitude of a possibly signed operand; |MIN| still fits unsigned WIDTH.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? ~x + WIDTH'(1) : x;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    dvnd_nx      = div_dvnd;
    dvsr_nx      = div_dvsr;
    q_cap_nx     = q_cap;
    r_cap_nx     = r_cap;
    out_q_nx     = bus.out_q;
    out_r_nx     = bus.out_r;
    neg_q_nx     = neg_q;
    neg_r_nx     = neg_r;
    ovf_pend_nx  = ovf_pend;
    cnt_nx       = cnt;
    in_ready_nx  = bus.in_ready;
    div_run_nx   = 1'b0;
    out_valid_nx = bus.out_valid;
    dz_nx        = bus.out_dz;
    ovf_nx       = bus.out_ovf;
    err_nx       = bus.out_err;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          neg_q_nx    = bus.in_sgn & (bus.in_dvnd[WIDTH-1] ^ bus.in_dvsr[WIDTH-1]);
          neg_r_nx    = bus.in_sgn & bus.in_dvnd[WIDTH-1];
          ovf_pend_nx = bus.in_sgn && (bus.in_dvnd == MIN) && (bus.in_dvsr == ONES);
          dvnd_nx     = mag(bus.in_dvnd, bus.in_sgn);
          dvsr_nx     = mag(bus.in_dvsr, bus.in_sgn);
          in_ready_nx = 1'b0;
          dz_nx       = 1'b0;
          ovf_nx      = 1'b0;
          err_nx      = 1'b0;
          if (bus.in_dvsr == '0) begin
            state_nx     = DONE;
            out_valid_nx = 1'b1;
            out_q_nx     = ONES;
            out_r_nx     = bus.in_dvnd;
            dz_nx        = 1'b1;
          end else begin
            state_nx   = ISSUE;
            div_run_nx = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_nx = WAIT;
        cnt_nx   = '0;
      end
      WAIT: begin
        // First WAIT cycle (cnt==0) ignores a ready left over from the previous op.
        if (cnt != '0 && div_rdy) begin
          q_cap_nx = div_q;
          r_cap_nx = div_r;
          state_nx = FIX;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nx     = DONE;
          out_valid_nx = 1'b1;
          out_q_nx     = '0;
          out_r_nx     = '0;
          err_nx       = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      FIX: begin
        out_q_nx     = neg_q ? -q_cap : q_cap;
        out_r_nx     = neg_r ? -r_cap : r_cap;
        ovf_nx       = ovf_pend;
        out_valid_nx = 1'b1;
        state_nx     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx     = IDLE;
          out_valid_nx = 1'b0;
          in_ready_nx  = 1'b1;
        end
      end
      default: begin
        state_nx     = IDLE;
        in_ready_nx  = 1'b1;
        out_valid_nx = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state         <= IDLE;
      div_dvnd      <= '0;
      div_dvsr      <= '0;
      div_run       <= 1'b0;
      q_cap         <= '0;
      r_cap         <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      ovf_pend      <= 1'b0;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_q     <= '0;
      bus.out_r     <= '0;
      bus.out_dz    <= 1'b0;
      bus.out_ovf   <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      state         <= state_nx;
      div_dvnd      <= dvnd_nx;
      div_dvsr      <= dvsr_nx;
      div_run       <= div_run_nx;
      q_cap         <= q_cap_nx;
      r_cap         <= r_cap_nx;
      neg_q         <= neg_q_nx;
      neg_r         <= neg_r_nx;
      ovf_pend      <= ovf_pend_nx;
      cnt           <= cnt_nx;
      bus.in_ready  <= in_ready_nx;
      bus.out_valid <= out_valid_nx;
      bus.out_q     <= out_q_nx;
      bus.out_r     <= out_r_nx;
      bus.out_dz    <= dz_nx;
      bus.out_ovf   <= ovf_nx;
      bus.out_err   <= err_nx;
    end
  end
endmodule

// File: tb/tb_signed_div_sequencer.sv
// Directed bench for signed_div_sequencer with a behavioural divider model.
module tb_signed_div_sequencer;
  localparam int unsigned W   = 32;
  localparam int unsigned TO  = 80;
  localparam int          LAT = 4;

  logic         clk = 1'b0;
  logic         Rst;
  logic [W-1:0] div_dvnd, div_dvsr, div_q, div_r;
  logic         div_run, div_rdy;
  logic         hang = 1'b0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           run_cnt = 0;

  signed_div_sequencer_if #(.WIDTH(W)) bus ();

  signed_div_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .Rst      (Rst),
    .bus      (bus),
    .div_dvnd (div_dvnd),
    .div_dvsr (div_dvsr),
    .div_run  (div_run),
    .div_q    (div_q),
    .div_r    (div_r),
    .div_rdy  (div_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (div_run) run_cnt <= run_cnt + 1;

  // Divider model: ready stays high after a result and drops one cycle after run.
  logic [W-1:0] m_a, m_b;
  logic         run_d;
  int           m_cnt;
  always @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      m_a <= '0; m_b <= '0; m_cnt <= 0; run_d <= 1'b0;
      div_q <= '0; div_r <= '0; div_rdy <= 1'b0;
    end else begin
      run_d <= div_run;
      if (div_run) begin
        m_a <= div_dvnd; m_b <= div_dvsr; m_cnt <= LAT;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !hang) begin
          div_q <= m_a / m_b; div_r <= m_a % m_b; div_rdy <= 1'b1;
        end
      end
      if (run_d) div_rdy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    check({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
    bus.in_valid = 1'b1; bus.in_dvnd = a; bus.in_dvsr = b; bus.in_sgn = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // One request end to end; hold = cycles to keep out_ready low once valid.
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                    input logic [W-1:0] eq, input logic [W-1:0] er,
                    input logic edz, input logic eovf, input logic eerr,
                    input int elat, input int eruns, input logic chk_div,
                    input logic [W-1:0] ednd, input logic [W-1:0] edsr, input int hold);
    int lat;
    int runs0;
    runs0 = run_cnt;
    start(tag, a, b, s);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, W'(lat), W'(elat));
    check({tag, "_runs"}, W'(run_cnt - runs0), W'(eruns));
    check({tag, "_q"}, bus.out_q, eq);
    check({tag, "_r"}, bus.out_r, er);
    check({tag, "_dz"}, W'(bus.out_dz), W'(edz));
    check({tag, "_ovf"}, W'(bus.out_ovf), W'(eovf));
    check({tag, "_err"}, W'(bus.out_err), W'(eerr));
    if (chk_div) begin
      check({tag, "_div_dvnd"}, div_dvnd, ednd);
      check({tag, "_div_dvsr"}, div_dvsr, edsr);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, W'(bus.out_valid), W'(1));
      check({tag, "_hold_q"}, bus.out_q, eq);
      check({tag, "_hold_r"}, bus.out_r, er);
      check({tag, "_hold_in_ready"}, W'(bus.in_ready), W'(0));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, W'(bus.out_valid), W'(0));
    check({tag, "_ready_back"}, W'(bus.in_ready), W'(1));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
    check({tag, "_out_valid"}, W'(bus.out_valid), W'(0));
    check({tag, "_div_run"}, W'(div_run), W'(0));
    check({tag, "_div_dvnd"}, div_dvnd, '0);
    check({tag, "_out_q"}, bus.out_q, '0);
    check({tag, "_out_r"}, bus.out_r, '0);
    check({tag, "_flags"}, W'({bus.out_dz, bus.out_ovf, bus.out_err}), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_dvnd = '0; bus.in_dvsr = '0; bus.in_sgn = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    Rst = 1'b1;

    // tag, a, b, sgn, q, r, dz, ovf, err, latency, runs, chk_div, div_dvnd, div_dvsr, hold
    op("neg7_by2", 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
       1'b0, 1'b0, 1'b0, 8, 1, 1'b1, 32'h7, 32'h2, 0);
    op("u_ffff_by16", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF,
       1'b0, 1'b0, 1'b0, 8, 1, 1'b1, 32'hFFFF_FFFF, 32'h10, 0);
    op("min_by_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0,
       1'b0, 1'b1, 1'b0, 8, 1, 1'b1, 32'h8000_0000, 32'h1, 0);
    op("div_zero", 32'd123, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'd123,
       1'b1, 1'b0, 1'b0, 1, 0, 1'b0, '0, '0, 0);
    op("p7_by_m2", 32'h7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h1,
       1'b0, 1'b0, 1'b0, 8, 1, 1'b1, 32'h7, 32'h2, 0);
    op("m7_by_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'h3, 32'hFFFF_FFFF,
       1'b0, 1'b0, 1'b0, 8, 1, 1'b1, 32'h7, 32'h2, 0);
    op("u_min_by_ones", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000,
       1'b0, 1'b0, 1'b0, 8, 1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    op("hold_100_by7", 32'd100, 32'd7, 1'b1, 32'd14, 32'd2,
       1'b0, 1'b0, 1'b0, 8, 1, 1'b1, 32'd100, 32'd7, 5);

    hang = 1'b1;
    op("timeout", 32'd50, 32'd5, 1'b0, 32'h0, 32'h0,
       1'b0, 1'b0, 1'b1, int'(TO) + 2, 1, 1'b0, '0, '0, 0);
    hang = 1'b0;

    // Reset while waiting on the divider abandons the request.
    start("rst_wait", 32'd100, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    #1;
    check_reset_state("rst_wait");
    @(negedge clk);
    Rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_wait_no_result", W'(bus.out_valid), W'(0));

    op("after_rst", 32'd1000, 32'd7, 1'b0, 32'd142, 32'd6,
       1'b0, 1'b0, 1'b0, 8, 1, 1'b1, 32'd1000, 32'd7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
